// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Registered MIPS writeback stage. Accepts one retiring instruction from the
// MEM stage, selects its result (ALU, load data or link address), waits for
// variable-latency load data when needed, sign/zero-extends sub-word loads and
// presents a one-cycle register-file write pulse. Also counts retirements.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   MEM-stage handshake (accept on valid & ready)
//   in_src              0 ALU, 1 MEM, 2 LINK, 3 NONE (no register write)
//   in_load_type        0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5-7 treated as LW
//   in_byte_off         address[1:0] of the load
//   in_rd, in_alu, in_pc  destination register, ALU result, instruction PC
//   mem_rvalid/mem_rdata  load data return (aligned word, little-endian lanes)
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   busy                high while waiting for load data
//   retired_count       number of instructions retired (wraps)
// -----------------------------------------------------------------------------
module writeback_stage #(
   parameter int WIDTH       = 32,
   parameter int REG_AW      = 5,
   parameter int LINK_OFFSET = 4,
   parameter int COUNT_W     = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_src,
   input  logic [2:0]         in_load_type,
   input  logic [1:0]         in_byte_off,
   input  logic [REG_AW-1:0]  in_rd,
   input  logic [WIDTH-1:0]   in_alu,
   input  logic [WIDTH-1:0]   in_pc,
   input  logic               mem_rvalid,
   input  logic [WIDTH-1:0]   mem_rdata,
   output logic               rf_we,
   output logic [REG_AW-1:0]  rf_waddr,
   output logic [WIDTH-1:0]   rf_wdata,
   output logic               busy,
   output logic [COUNT_W-1:0] retired_count
);

   typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

   localparam logic [1:0] SRC_ALU  = 2'd0;
   localparam logic [1:0] SRC_MEM  = 2'd1;
   localparam logic [1:0] SRC_LINK = 2'd2;

   localparam logic [2:0] LD_LH  = 3'd1;
   localparam logic [2:0] LD_LHU = 3'd2;
   localparam logic [2:0] LD_LB  = 3'd3;
   localparam logic [2:0] LD_LBU = 3'd4;

   state_t             state_q, state_d;
   logic               rf_we_q, rf_we_d;
   logic [REG_AW-1:0]  rf_waddr_q, rf_waddr_d;
   logic [WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
   logic [COUNT_W-1:0] count_q, count_d;
   // Fields of the load waiting for its data.
   logic [REG_AW-1:0]  ld_rd_q, ld_rd_d;
   logic [2:0]         ld_type_q, ld_type_d;
   logic [1:0]         ld_off_q, ld_off_d;

   logic accept;

   // Lane select plus extension of the returned word.
   function automatic logic [WIDTH-1:0] extend_load(input logic [2:0]       lt,
                                                    input logic [1:0]       off,
                                                    input logic [WIDTH-1:0] w);
      logic [15:0] half_v;
      logic [7:0]  byte_v;
      logic [WIDTH-1:0] res;
      half_v = off[1] ? w[31:16] : w[15:0];
      case (off)
         2'd0:    byte_v = w[7:0];
         2'd1:    byte_v = w[15:8];
         2'd2:    byte_v = w[23:16];
         default: byte_v = w[31:24];
      endcase
      case (lt)
         LD_LH:   res = {{(WIDTH-16){half_v[15]}}, half_v};
         LD_LHU:  res = {{(WIDTH-16){1'b0}}, half_v};
         LD_LB:   res = {{(WIDTH-8){byte_v[7]}}, byte_v};
         LD_LBU:  res = {{(WIDTH-8){1'b0}}, byte_v};
         default: res = w;
      endcase
      return res;
   endfunction

   // Ready depends on state only, so the upstream stage never sees a
   // combinational loop through in_valid.
   assign in_ready = (state_q != WAIT_MEM);
   assign accept   = in_valid && in_ready;

   always_comb begin
      // NOTE: every signal gets a default here so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      rf_we_d    = rf_we_q;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      count_d    = count_q;
      ld_rd_d    = ld_rd_q;
      ld_type_d  = ld_type_q;
      ld_off_d   = ld_off_q;

      case (state_q)
         WAIT_MEM: begin
            // Data returning on the accept edge itself is never seen here,
            // because this state is only reached after that edge.
            if (mem_rvalid) begin
               state_d    = WRITE;
               rf_we_d    = (ld_rd_q != '0);
               rf_waddr_d = ld_rd_q;
               rf_wdata_d = extend_load(ld_type_q, ld_off_q, mem_rdata);
               count_d    = count_q + COUNT_W'(1);
            end
         end
         default: begin // IDLE and WRITE accept identically
            if (accept) begin
               if (in_src == SRC_MEM) begin
                  state_d   = WAIT_MEM;
                  rf_we_d   = 1'b0;
                  ld_rd_d   = in_rd;
                  ld_type_d = in_load_type;
                  ld_off_d  = in_byte_off;
               end else begin
                  state_d    = WRITE;
                  rf_we_d    = (in_src != 2'd3) && (in_rd != '0);
                  rf_waddr_d = in_rd;
                  case (in_src)
                     SRC_ALU:  rf_wdata_d = in_alu;
                     SRC_LINK: rf_wdata_d = in_pc + WIDTH'(LINK_OFFSET);
                     default:  rf_wdata_d = '0;
                  endcase
                  count_d    = count_q + COUNT_W'(1);
               end
            end else begin
               // Write data and address hold; only the pulse drops.
               state_d = IDLE;
               rf_we_d = 1'b0;
            end
         end
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples the values from
   // before this edge, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         count_q    <= '0;
         ld_rd_q    <= '0;
         ld_type_q  <= '0;
         ld_off_q   <= '0;
      end else begin
         state_q    <= state_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         count_q    <= count_d;
         ld_rd_q    <= ld_rd_d;
         ld_type_q  <= ld_type_d;
         ld_off_q   <= ld_off_d;
      end
   end

   assign rf_we         = rf_we_q;
   assign rf_waddr      = rf_waddr_q;
   assign rf_wdata      = rf_wdata_q;
   assign busy          = (state_q == WAIT_MEM);
   assign retired_count = count_q;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Registered MIPS writeback stage. It replaces the combinational write-data select with a handshaked, multi-cycle block.
- It accepts one retiring instruction from the MEM stage and picks its result: ALU, load data, or link address.
- Load data may arrive with variable latency. The block sign- or zero-extends sub-word loads.
- It drives the register-file write port with a one-cycle write pulse and counts retired instructions.

Parameters:
- WIDTH, 32, datapath width; must be 32 for sub-word load handling.
- REG_AW, 5, register address width.
- LINK_OFFSET, 4, value added to in_pc for link writes (JAL/JALR).
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  block accepts on (in_valid & in_ready) at a rising edge.
- in_src  in  2  result source: 0 ALU, 1 MEM, 2 LINK, 3 NONE (no register write, e.g. SW or branch).
- in_load_type  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; codes 5-7 behave as LW.
- in_byte_off  in  2  address[1:0] of the load.
- in_rd  in  REG_AW  destination register.
- in_alu  in  WIDTH  ALU result.
- in_pc  in  WIDTH  PC of the instruction.
- mem_rvalid  in  1  load data valid this cycle.
- mem_rdata  in  WIDTH  aligned memory word, little-endian lanes (byte k = bits 8k+7:8k).
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  REG_AW  write address, registered.
- rf_wdata  out  WIDTH  write data, registered.
- busy  out  1  high while in WAIT_MEM.
- retired_count  out  COUNT_W  number of instructions retired.

Behaviour:
- Reset (async, any state): state = IDLE; rf_we = 0; rf_waddr = 0; rf_wdata = 0; retired_count = 0; any pending load is dropped.
- States:
  - IDLE: no instruction in flight.
  - WAIT_MEM: load accepted, data not yet received.
  - WRITE: write pulse being presented.
- in_ready = (state != WAIT_MEM). It is combinational from state only, never from in_valid.
- Accept with in_src = ALU, LINK or NONE:
  - Go to WRITE next cycle; rf_waddr = in_rd.
  - rf_wdata = in_alu (ALU), in_pc + LINK_OFFSET modulo 2^WIDTH (LINK), or 0 (NONE).
  - rf_we = 1 only if src != NONE and in_rd != 0.
  - Latency: 1 cycle from the accept edge to the rf_we high cycle.
- Accept with in_src = MEM: latch rd, load_type and byte_off; go to WAIT_MEM; rf_we = 0.
- In WAIT_MEM:
  - Sample mem_rdata on the first cycle mem_rvalid = 1; go to WRITE.
  - rf_wdata = extended load value; rf_we = (rd != 0).
  - mem_rvalid in the same cycle as the MEM accept is not used for that load.
- Load extension:
  - LW: full word; byte_off ignored.
  - LH/LHU: halfword at lane byte_off[1]; byte_off[0] ignored; sign- or zero-extend to WIDTH.
  - LB/LBU: byte at lane byte_off; sign- or zero-extend to WIDTH.
- In WRITE:
  - rf_we is high for exactly this one cycle unless a new write-producing accept occurs on the same edge.
  - A new accept in WRITE follows the IDLE rules, giving back-to-back writes every cycle.
  - With no accept, return to IDLE and clear rf_we. rf_waddr and rf_wdata hold their last values.
- retired_count increments by 1 on every entry to WRITE, NONE and rd = 0 included. It wraps at 2^COUNT_W.
- mem_rvalid in IDLE or WRITE is ignored.
- rf_waddr and rf_wdata change only on entry to WRITE.
- busy = (state == WAIT_MEM).

Test Plan:
- Reset then ALU accept (rd = 8, in_alu = 88) -> next cycle rf_we = 1, rf_waddr = 8, rf_wdata = 88; cycle after, rf_we = 0; retired_count = 1.
- LINK accept (in_pc = 12, rd = 31) -> next cycle rf_wdata = 16, rf_waddr = 31.
- MEM LW (rd = 9); mem_rvalid asserted 3 cycles later with mem_rdata = 99 -> busy = 1 and in_ready = 0 while waiting; rf_wdata = 99 one cycle after rvalid; rf_we pulses once.
- Sub-word loads with mem_rdata = 0x80F1_7F82:
  - LB off 0 -> 0xFFFF_FF82
  - LBU off 0 -> 0x0000_0082
  - LB off 1 -> 0x0000_007F
  - LH off 2 -> 0xFFFF_80F1
  - LHU off 2 -> 0x0000_80F1
- Back-to-back ALU accepts for 4 cycles (rd 1..4) -> rf_we high 4 consecutive cycles, matching addresses/data; retired_count = 4. ALU to rd = 0 -> rf_we stays 0, retired_count increments.
- Reset asserted mid-WAIT_MEM, then a late mem_rvalid -> all outputs 0, in_ready = 1, no write occurs.
